// File: rtl/divider_pkg.sv
// Shared encodings for the iterative divider: operation select and FSM states.
// Also holds small decode helpers for the operation field.
package divider_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_e;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-and-subtract iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_divisor,
   input  logic            i_bit,
   output logic [XLEN-1:0] o_rem,
   output logic            o_q
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;

   // The partial remainder is always below the divisor, so the shifted value
   // needs only one extra bit and the restored result fits back in XLEN bits.
   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_divisor};
   assign o_q     = ~w_diff[XLEN];
   assign o_rem   = o_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: XLEN iterations on operand
// magnitudes, one sign-fix cycle, and a held result until the consumer accepts.
module iterative_divider
   import divider_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      r_state;
   div_state_e      w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_dvs;
   logic            r_is_rem;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [XLEN-1:0] r_result;

   div_op_e         w_op;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_div_zero;
   logic            w_overflow;
   logic            w_bypass;
   logic [XLEN-1:0] w_bypass_res;
   logic            w_accept;
   logic            w_last;
   logic [XLEN-1:0] w_step_rem;
   logic            w_step_q;
   logic [XLEN-1:0] w_fix_res;

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   assign w_op       = div_op_e'(op_i);
   assign w_signed   = op_is_signed(w_op);
   assign w_a_neg    = w_signed & operand1_i[XLEN-1];
   assign w_b_neg    = w_signed & operand2_i[XLEN-1];
   assign w_mag_a    = w_a_neg ? (~operand1_i + 1'b1) : operand1_i;
   assign w_mag_b    = w_b_neg ? (~operand2_i + 1'b1) : operand2_i;
   assign w_div_zero = (operand2_i == '0);
   assign w_overflow = w_signed && (operand1_i == MOST_NEG) && (operand2_i == '1);
   assign w_bypass   = w_div_zero | w_overflow;

   // Divide-by-zero: quotient all ones, remainder = dividend.
   // Signed overflow: quotient = dividend, remainder = 0.
   always_comb begin
      w_bypass_res = '0;
      if (w_div_zero) begin
         w_bypass_res = op_is_rem(w_op) ? operand1_i : '1;
      end else if (w_overflow) begin
         w_bypass_res = op_is_rem(w_op) ? '0 : operand1_i;
      end
   end

   assign ready_o  = (r_state == IDLE) && !flush_i;
   assign w_accept = valid_i && ready_o;
   assign w_last   = (r_cnt == CNT_LAST);

   // ---------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------
   div_step #(.XLEN(XLEN)) u_step (
      .i_rem     (r_rem),
      .i_divisor (r_dvs),
      .i_bit     (r_quo[XLEN-1]),
      .o_rem     (w_step_rem),
      .o_q       (w_step_q)
   );

   assign w_fix_res = r_is_rem ? (r_neg_r ? (~r_rem + 1'b1) : r_rem)
                               : (r_neg_q ? (~r_quo + 1'b1) : r_quo);

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (flush_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (valid_i) w_state_next = w_bypass ? DONE : CALC;
            CALC: if (w_last)  w_state_next = FIX;
            FIX:               w_state_next = DONE;
            DONE: if (ready_i) w_state_next = IDLE;
            default:           w_state_next = IDLE;
         endcase
      end
   end

   // The dividend shifts out of r_quo's MSB while quotient bits shift in at the LSB.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else if (flush_i) begin
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cnt    <= '0;
                  r_rem    <= '0;
                  r_quo    <= w_mag_a;
                  r_dvs    <= w_mag_b;
                  r_is_rem <= op_is_rem(w_op);
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_result <= w_bypass ? w_bypass_res : '0;
               end
            end
            CALC: begin
               r_rem <= w_step_rem;
               r_quo <= {r_quo[XLEN-2:0], w_step_q};
               r_cnt <= r_cnt + 1'b1;
            end
            FIX: begin
               r_result <= w_fix_res;
            end
            default: ;
         endcase
      end
   end

   assign valid_o  = (r_state == DONE);
   assign result_o = valid_o ? r_result : '0;

endmodule
